div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter BITS_PER_CYCLE, default 1, giving quotient bits resolved per CALC cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-low reset (asserted at 0).
REQ-004 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 The block SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have port dividend  input  32  operand a; sampled with start.
REQ-007 The block SHALL have port divisor  input  32  operand b; sampled with start.
REQ-008 The block SHALL have port flush  input  1  synchronous abort of any operation in progress.
REQ-009 The block SHALL have port busy  output  1  high whenever state is not IDLE; the pipeline stalls on it.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-011 The block SHALL have port result  output  32  quotient or remainder; holds its value until the next accepted start.

Function
REQ-012 The state machine SHALL have states IDLE, PREP, CALC, FIX and DONE.
REQ-013 IDLE with start=1 and flush=0 SHALL latch op and both operands and move to PREP.
- Start in any other state is ignored and not queued.
REQ-014 PREP SHALL do the following:
- Signed ops: take absolute values; record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
- Clear the partial remainder and load the iteration counter with N = 32/BITS_PER_CYCLE.
REQ-015 PREP SHALL go to DONE when divisor = 0 or overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF); otherwise it SHALL go to CALC.
REQ-016 CALC SHALL perform BITS_PER_CYCLE restoring-division steps per cycle, decrement the counter each cycle, and go to FIX after exactly N cycles.
- The partial remainder is 33 bits wide so the trial subtract cannot lose its borrow.
REQ-017 FIX SHALL negate the quotient/remainder per the recorded signs (signed ops only), load result, and go to DONE.
REQ-018 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-019 Latency for a normal operation SHALL be N+3 rising edges from the edge sampling start to the first edge with done=1 (35 at the default parameter).
- Special cases take 2 edges.
REQ-020 Divide by zero SHALL give:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: the dividend.
REQ-021 Overflow SHALL give:
- DIV: 0x80000000.
- REM: 0x00000000.
REQ-022 Signed results SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge.
- done is not asserted and result is unchanged.
- flush overrides a simultaneous start.
REQ-024 busy SHALL be 1 in PREP, CALC, FIX and DONE, and 0 only in IDLE.
- A new start is accepted at the earliest on the edge after DONE.
REQ-025 Operand inputs SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the result.

Reset
REQ-026 rst=0 SHALL asynchronously force the following, regardless of clk:
- state IDLE, busy=0, done=0, result=0x00000000.
- counter and internal registers cleared.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
- After release, the block SHALL accept start on the first rising edge.

Verification
REQ-028 DIV 100 / 7 -> done after 35 edges, result 0x0000000E; busy high for 35 edges.
REQ-029 REM 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFF (-1); DIV of the same operands -> 0xFFFFFFFD (-3).
REQ-030 DIVU 5 / 0 -> done after 2 edges, result 0xFFFFFFFF; REMU 5 / 0 -> 0x00000005.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 after 2 edges; REM of the same operands -> 0x00000000.
REQ-032 DIVU 0xFFFFFFFF / 3 started, flush at CALC cycle 10 -> IDLE next edge, no done, result retains the previous value; second start accepted 1 edge later.
REQ-033 Start while busy, and rst pulsed low mid-CALC, together cover:
- Start while busy -> ignored; the first result is unaffected.
- rst low mid-CALC -> outputs zero immediately; no done pulse.

Source files
------------

// File: rtl/div_seq.sv
// Purpose : sequential 32-bit integer divider (DIV/DIVU/REM/REMU), restoring algorithm.
// Latency : 32/BITS_PER_CYCLE + 3 edges normal, 2 edges for divide-by-zero / signed overflow.
// Backpressure: none; busy is high for the whole operation and start is ignored while busy.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-low reset
//   start     request, sampled only in IDLE
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  operand a, sampled with start
//   divisor   operand b, sampled with start
//   flush     synchronous abort, overrides start
//   busy      high whenever the FSM is not in IDLE
//   done      one-cycle pulse, result valid
//   result    quotient or remainder, held until overwritten by a later completion
//
// BITS_PER_CYCLE must be 1, 2 or 4.

module div_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [5:0] N_ITER = 6'(32 / BITS_PER_CYCLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_quo;      // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [32:0] r_rem;      // partial remainder
    logic [31:0] r_dvs;      // magnitude of divisor
    logic [5:0]  r_cnt;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic        w_div0;
    logic        w_ovf;
    logic [32:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // op[0]=0 selects the signed variants (DIV, REM)
    assign w_signed = ~r_op[0];
    assign w_a_abs  = (w_signed && r_a[31]) ? -r_a : r_a;
    assign w_b_abs  = (w_signed && r_b[31]) ? -r_b : r_b;
    assign w_div0   = (r_b == 32'h0000_0000);
    assign w_ovf    = w_signed && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);

    // BITS_PER_CYCLE chained restoring steps. The trial subtract is done one bit
    // wider than the shifted remainder so its borrow is never lost.
    always_comb begin
        w_rem_nx = r_rem;
        w_quo_nx = r_quo;
        w_shift  = '0;
        w_diff   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_shift  = {w_rem_nx[31:0], w_quo_nx[31]};
            w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
            w_quo_nx = {w_quo_nx[30:0], ~w_diff[33]};
            if (!w_diff[33]) begin
                w_rem_nx = w_diff[32:0];
            end else begin
                w_rem_nx = w_shift;
            end
        end
    end

    // Sign fix-up: quotient negative when operand signs differ, remainder follows the dividend.
    assign w_q_fix = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix = r_r_neg ? -r_rem[31:0] : r_rem[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            // abort: no done pulse, result left untouched
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_a     <= dividend;
                        r_b     <= divisor;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end

                S_PREP: begin
                    r_rem   <= '0;
                    r_cnt   <= N_ITER;
                    r_quo   <= w_a_abs;
                    r_dvs   <= w_b_abs;
                    r_q_neg <= w_signed && (r_a[31] ^ r_b[31]);
                    r_r_neg <= w_signed && r_a[31];
                    if (w_div0) begin
                        r_result <= r_op[1] ? r_a : 32'hFFFF_FFFF;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_ovf) begin
                        r_result <= r_op[1] ? 32'h0000_0000 : 32'h8000_0000;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_CALC;
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    r_result <= r_op[1] ? w_r_fix : w_q_fix;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
